// File: rtl/cell_assembler_if.sv
// -----------------------------------------------------------------------------
// cell_assembler_if
// Purpose : bundles the pixel-beat input stream, the assembled-cell output
//           stream, the flush control and the beat index of cell_assembler.
// Ports   : flush_i     - synchronous abort of the partial cell
//           pxl_i       - one beat (CELL_ROW_PNUM pixels, pixel 0 in MSBs)
//           pxl_vld_i   - pxl_i valid
//           pxl_rdy_o   - beat accepted when pxl_vld_i & pxl_rdy_o
//           cell_o      - assembled cell {ipxl, t, l, r, b}
//           cell_vld_o  - cell_o valid
//           cell_rdy_i  - cell transferred when cell_vld_o & cell_rdy_i
//           beat_idx_o  - index of the next beat to be accepted
// Modports: slave  - the assembler itself
//           master - the environment feeding beats and draining cells
// -----------------------------------------------------------------------------
interface cell_assembler_if #(
   parameter int CELL_WIDTH    = 768,
   parameter int PIXEL_WIDTH   = 8,
   parameter int CELL_ROW_PNUM = 8
) ();
   localparam int BEAT_W = CELL_ROW_PNUM * PIXEL_WIDTH;

   logic                  flush_i;
   logic [BEAT_W-1:0]     pxl_i;
   logic                  pxl_vld_i;
   logic                  pxl_rdy_o;
   logic [CELL_WIDTH-1:0] cell_o;
   logic                  cell_vld_o;
   logic                  cell_rdy_i;
   logic [3:0]            beat_idx_o;

   modport slave (
      input  flush_i, pxl_i, pxl_vld_i, cell_rdy_i,
      output pxl_rdy_o, cell_o, cell_vld_o, beat_idx_o
   );

   modport master (
      output flush_i, pxl_i, pxl_vld_i, cell_rdy_i,
      input  pxl_rdy_o, cell_o, cell_vld_o, beat_idx_o
   );
endinterface

// File: rtl/cell_assembler.sv
// -----------------------------------------------------------------------------
// cell_assembler
// Purpose : collects NBEAT beats of CELL_ROW_PNUM pixels (inner rows 0..7,
//           then top, left, right, bottom borders) into one CELL_WIDTH cell
//           and hands it to the masking stage through a one-deep output
//           register with valid/ready handshake.
// Ports   : clk_i - clock, all state on rising edge
//           rst_i - asynchronous active-high reset
//           bus   - cell_assembler_if.slave (beat input, cell output, flush,
//                   beat index)
// -----------------------------------------------------------------------------
module cell_assembler #(
   parameter int CELL_WIDTH    = 768,
   parameter int PIXEL_WIDTH   = 8,
   parameter int CELL_ROW_PNUM = 8,
   parameter int CELL_COL_PNUM = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   cell_assembler_if.slave bus
);
   localparam int         BEAT_W   = CELL_ROW_PNUM * PIXEL_WIDTH;
   localparam int         NBEAT    = CELL_WIDTH / BEAT_W;
   localparam logic [3:0] LAST_IDX = 4'(NBEAT - 1);

   // Cells are square and must split into whole beats.
   if ((CELL_COL_PNUM != CELL_ROW_PNUM) || ((CELL_WIDTH % BEAT_W) != 0)) begin : g_bad_cfg
      $error("cell_assembler: unsupported geometry");
   end

   logic [3:0]            cnt_r;
   logic [CELL_WIDTH-1:0] asm_r;
   logic [CELL_WIDTH-1:0] cell_r;
   logic                  cell_vld_r;

   logic                  is_last_s;
   logic                  pxl_rdy_s;
   logic                  accept_s;
   logic                  load_s;
   logic [CELL_WIDTH-1:0] asm_next_s;

   // Input ready: only the final beat waits for room in the output register;
   // it may complete in the same cycle the pending cell drains.
   always_comb begin
      is_last_s = (cnt_r == LAST_IDX);
      if (bus.flush_i) begin
         pxl_rdy_s = 1'b0;
      end else if (is_last_s) begin
         pxl_rdy_s = ~cell_vld_r | bus.cell_rdy_i;
      end else begin
         pxl_rdy_s = 1'b1;
      end
      accept_s = bus.pxl_vld_i & pxl_rdy_s;
      load_s   = accept_s & is_last_s;
   end

   // Assembly image with the current beat dropped into its slot; beat k
   // occupies the k-th BEAT_W field counted from the MSB end.
   always_comb begin
      asm_next_s = asm_r;
      for (int k = 0; k < NBEAT; k++) begin
         asm_next_s[CELL_WIDTH-1-k*BEAT_W -: BEAT_W] =
            (cnt_r == 4'(k)) ? bus.pxl_i : asm_r[CELL_WIDTH-1-k*BEAT_W -: BEAT_W];
      end
   end

   // Beat counter and assembly register; flush wins over a same-cycle beat.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_r <= 4'd0;
         asm_r <= '0;
      end else if (bus.flush_i) begin
         cnt_r <= 4'd0;
         asm_r <= '0;
      end else if (accept_s) begin
         asm_r <= asm_next_s;
         cnt_r <= is_last_s ? 4'd0 : cnt_r + 4'd1;
      end else begin
         cnt_r <= cnt_r;
         asm_r <= asm_r;
      end
   end

   // Output register: a new cell reloads it (even while the old one drains),
   // otherwise valid drops on handshake and data holds.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cell_r     <= '0;
         cell_vld_r <= 1'b0;
      end else if (load_s) begin
         cell_r     <= asm_next_s;
         cell_vld_r <= 1'b1;
      end else if (bus.cell_rdy_i) begin
         cell_r     <= cell_r;
         cell_vld_r <= 1'b0;
      end else begin
         cell_r     <= cell_r;
         cell_vld_r <= cell_vld_r;
      end
   end

   assign bus.pxl_rdy_o  = pxl_rdy_s;
   assign bus.cell_o     = cell_r;
   assign bus.cell_vld_o = cell_vld_r;
   assign bus.beat_idx_o = cnt_r;
endmodule

// File: tb/tb_cell_assembler.sv
// -----------------------------------------------------------------------------
// tb_cell_assembler
// Directed and randomised stimulus for cell_assembler. A cycle model sampled
// on the falling edge predicts ready/index/valid and pushes every completed
// cell into a scoreboard queue that is popped on each output handshake.
// -----------------------------------------------------------------------------
module tb_cell_assembler;
   localparam int CW = 768;
   localparam int BW = 64;
   localparam int NB = 12;

   logic clk;
   logic rst;

   cell_assembler_if bus_if ();

   cell_assembler dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_if)
   );

   int pass_cnt  = 0;
   int check_cnt = 0;
   int fail_cnt  = 0;

   logic [CW-1:0] exp_q[$];
   logic [CW-1:0] m_asm = '0;
   int            m_cnt = 0;
   logic          m_vld = 1'b0;
   logic          mon_rdy;
   logic          mon_acc;
   logic          mon_last;

   logic win_en      = 1'b0;
   int   win_vld     = 0;
   int   win_rdy_low = 0;
   int   dut_xfer    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Cycle model and scoreboard, sampled mid-cycle.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         mon_rdy = !bus_if.flush_i && ((m_cnt != NB-1) || !m_vld || bus_if.cell_rdy_i);
         chk("pxl_rdy_o", CW'(bus_if.pxl_rdy_o), CW'(mon_rdy));
         chk("beat_idx_o", CW'(bus_if.beat_idx_o), CW'(m_cnt));
         chk("cell_vld_o", CW'(bus_if.cell_vld_o), CW'(m_vld));
         if (win_en) begin
            if (bus_if.cell_vld_o) win_vld++;
            if (!bus_if.pxl_rdy_o) win_rdy_low++;
         end
         if (bus_if.cell_vld_o && bus_if.cell_rdy_i) dut_xfer++;
         if (m_vld && bus_if.cell_rdy_i && (exp_q.size() > 0)) begin
            chk("cell_o", bus_if.cell_o, exp_q.pop_front());
         end
         mon_acc  = bus_if.pxl_vld_i && mon_rdy;
         mon_last = (m_cnt == NB-1);
         if (bus_if.flush_i) begin
            m_cnt = 0;
            m_asm = '0;
         end else if (mon_acc) begin
            m_asm[CW-1-m_cnt*BW -: BW] = bus_if.pxl_i;
            if (mon_last) begin
               exp_q.push_back(m_asm);
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
         if (mon_acc && mon_last) m_vld = 1'b1;
         else if (bus_if.cell_rdy_i) m_vld = 1'b0;
      end
   end

   // Hold one beat until the DUT accepts it (bounded).
   task automatic send_beat(input logic [BW-1:0] d, input logic r);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      bus_if.pxl_vld_i  = 1'b1;
      bus_if.pxl_i      = d;
      bus_if.cell_rdy_i = r;
      bus_if.flush_i    = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = bus_if.pxl_rdy_o;
         @(posedge clk);
         #1;
         n++;
      end
      bus_if.pxl_vld_i = 1'b0;
      chk("beat_accept", CW'(acc), CW'(1'b1));
   endtask

   task automatic idle(input logic r, input int n);
      bus_if.pxl_vld_i  = 1'b0;
      bus_if.cell_rdy_i = r;
      bus_if.flush_i    = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BW-1:0] base;
      logic [BW-1:0] d;
      logic [BW-1:0] b11;
      logic [CW-1:0] c_exp;
      logic          got;
      int            acc_beats;
      int            cyc;

      base = 64'h0101010101010101;
      rst  = 1'b1;
      bus_if.pxl_vld_i  = 1'b0;
      bus_if.pxl_i      = '0;
      bus_if.cell_rdy_i = 1'b0;
      bus_if.flush_i    = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cell_vld", CW'(bus_if.cell_vld_o), CW'(1'b0));
      chk("rst_beat_idx", CW'(bus_if.beat_idx_o), CW'(4'd0));
      chk("rst_pxl_rdy", CW'(bus_if.pxl_rdy_o), CW'(1'b1));
      chk("rst_cell_o", bus_if.cell_o, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Twelve beats of k * 0x01.., cell one cycle after the last beat
      for (int k = 0; k < NB; k++) send_beat(base * 64'(k), 1'b1);
      chk("t1_cell_vld", CW'(bus_if.cell_vld_o), CW'(1'b1));
      chk("t1_top_beat", CW'(bus_if.cell_o[CW-1 -: BW]), CW'(64'd0));
      chk("t1_bottom_beat", CW'(bus_if.cell_o[BW-1:0]), CW'(base * 64'd11));
      idle(1'b1, 2);

      // Back-to-back with the sink stalled
      for (int k = 0; k < NB; k++) send_beat(rand64(), 1'b0);
      for (int k = 0; k < NB-1; k++) send_beat(rand64(), 1'b0);
      b11 = rand64();
      bus_if.pxl_vld_i  = 1'b1;
      bus_if.pxl_i      = b11;
      bus_if.cell_rdy_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t2_stall_rdy", CW'(bus_if.pxl_rdy_o), CW'(1'b0));
         chk("t2_stall_idx", CW'(bus_if.beat_idx_o), CW'(4'd11));
         @(posedge clk);
         #1;
      end
      bus_if.cell_rdy_i = 1'b1;
      @(negedge clk);
      chk("t2_release_rdy", CW'(bus_if.pxl_rdy_o), CW'(1'b1));
      @(posedge clk);
      #1;
      bus_if.pxl_vld_i = 1'b0;
      chk("t2_vld_kept", CW'(bus_if.cell_vld_o), CW'(1'b1));
      chk("t2_new_cell", CW'(bus_if.cell_o[BW-1:0]), CW'(b11));
      idle(1'b1, 2);

      // Flush together with beat 5 while a cell is pending
      for (int k = 0; k < NB; k++) send_beat(rand64(), 1'b0);
      for (int k = 0; k < 5; k++) send_beat(rand64(), 1'b0);
      c_exp = exp_q[0];
      bus_if.pxl_vld_i  = 1'b1;
      bus_if.pxl_i      = rand64();
      bus_if.flush_i    = 1'b1;
      bus_if.cell_rdy_i = 1'b0;
      @(negedge clk);
      chk("t3_flush_rdy", CW'(bus_if.pxl_rdy_o), CW'(1'b0));
      @(posedge clk);
      #1;
      bus_if.flush_i   = 1'b0;
      bus_if.pxl_vld_i = 1'b0;
      chk("t3_flush_idx", CW'(bus_if.beat_idx_o), CW'(4'd0));
      chk("t3_pending_vld", CW'(bus_if.cell_vld_o), CW'(1'b1));
      chk("t3_pending_cell", bus_if.cell_o, c_exp);
      for (int k = 0; k < NB; k++) send_beat(rand64(), 1'b1);
      idle(1'b1, 2);

      // Asynchronous reset at beat 7 with a cell pending
      for (int k = 0; k < NB; k++) send_beat(rand64(), 1'b0);
      for (int k = 0; k < 7; k++) send_beat(rand64(), 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t4_rst_vld", CW'(bus_if.cell_vld_o), CW'(1'b0));
      chk("t4_rst_idx", CW'(bus_if.beat_idx_o), CW'(4'd0));
      chk("t4_rst_rdy", CW'(bus_if.pxl_rdy_o), CW'(1'b1));
      m_cnt = 0;
      m_asm = '0;
      m_vld = 1'b0;
      exp_q.delete();
      #1;
      rst = 1'b0;
      for (int k = 0; k < NB; k++) send_beat(rand64(), 1'b1);
      idle(1'b1, 2);

      // Continuous streaming: one cell every 12 cycles, ready never low
      win_en = 1'b1;
      for (int k = 0; k < 3*NB; k++) send_beat(rand64(), 1'b1);
      idle(1'b1, 1);
      win_en = 1'b0;
      chk("t5_vld_pulses", CW'(win_vld), CW'(3));
      chk("t5_rdy_low", CW'(win_rdy_low), CW'(0));

      // Random gaps on both sides over 100 cells
      dut_xfer  = 0;
      acc_beats = 0;
      cyc       = 0;
      d         = rand64();
      while (acc_beats < 100*NB && cyc < 20000) begin
         bus_if.pxl_vld_i  = ($urandom_range(0, 3) != 0);
         bus_if.pxl_i      = d;
         bus_if.cell_rdy_i = ($urandom_range(0, 3) != 0);
         bus_if.flush_i    = 1'b0;
         @(negedge clk);
         got = bus_if.pxl_vld_i && bus_if.pxl_rdy_o;
         @(posedge clk);
         #1;
         cyc++;
         if (got) begin
            acc_beats++;
            d = rand64();
         end
      end
      idle(1'b1, 4);
      chk("t6_beats", CW'(acc_beats), CW'(100*NB));
      chk("t6_cells_out", CW'(dut_xfer), CW'(100));
      chk("t6_sb_empty", CW'(exp_q.size()), CW'(0));

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule

// File: doc/cell_assembler.md
CELL_ASSEMBLER -- requirements
Module: cell_assembler

Interface
- REQ-001: Parameter CELL_WIDTH, default 768: assembled cell width in bits.
- REQ-002: Parameter PIXEL_WIDTH, default 8: bits per pixel.
- REQ-003: Parameter CELL_ROW_PNUM, default 8: pixels per row and per beat.
- REQ-004: Parameter CELL_COL_PNUM, default 8: pixel rows per cell; SHALL equal CELL_ROW_PNUM.
- REQ-005: Derived BEAT_W = CELL_ROW_PNUM*PIXEL_WIDTH (64) and NBEAT = CELL_WIDTH/BEAT_W (12); CELL_WIDTH SHALL be an exact multiple of BEAT_W.
- REQ-006: clk_i, input, 1: the single clock; all state on rising edge.
- REQ-007: rst_i, input, 1: asynchronous, active-high reset.
- REQ-008: flush_i, input, 1: synchronous abort of the partially assembled cell.
- REQ-009: pxl_i, input, BEAT_W: one beat of CELL_ROW_PNUM pixels; pixel 0 in the MSBs.
- REQ-010: pxl_vld_i, input, 1: pxl_i valid.
- REQ-011: pxl_rdy_o, output, 1: beat accepted when pxl_vld_i & pxl_rdy_o.
- REQ-012: cell_o, output, CELL_WIDTH: assembled cell {ipxl, t, l, r, b}, the layout consumed by the cell masking stage.
- REQ-013: cell_vld_o, output, 1: cell_o valid.
- REQ-014: cell_rdy_i, input, 1: cell transferred when cell_vld_o & cell_rdy_i.
- REQ-015: beat_idx_o, output, 4: index of the next beat to be accepted (0..NBEAT-1).

Function
- REQ-016: Beat order SHALL be fixed: beats 0..7 are inner rows 0..7, beat 8 is top border, beat 9 left, beat 10 right, and beat 11 bottom.
- REQ-017: An accepted beat k SHALL be written to assembly bits [CELL_WIDTH-1-k*BEAT_W -: BEAT_W]; other assembly bits are unchanged.
- REQ-018: The beat counter SHALL increment by 1 per accepted beat and wrap from NBEAT-1 to 0; beat_idx_o equals the counter.
- REQ-019: For counter != NBEAT-1, pxl_rdy_o SHALL be 1 regardless of output state.
- REQ-020: For counter == NBEAT-1, pxl_rdy_o SHALL be ~cell_vld_o | cell_rdy_i, a combinational path from cell_rdy_i.
- REQ-021: On acceptance of beat NBEAT-1, the output register SHALL load the full assembly including that beat, and cell_vld_o SHALL be 1 the next cycle (latency 1 cycle from last beat).
- REQ-022: cell_vld_o SHALL clear on output handshake unless a new cell loads in the same cycle, in which case it stays 1 with the new data.
- REQ-023: cell_o SHALL hold stable while cell_vld_o & ~cell_rdy_i.
- REQ-024: Sustained throughput SHALL be one cell per NBEAT cycles with continuous pxl_vld_i and cell_rdy_i.
- REQ-025: flush_i SHALL zero the counter and assembly register next cycle, SHALL take priority over a same-cycle beat (the beat is dropped), and SHALL NOT affect cell_o or cell_vld_o.
- REQ-026: pxl_rdy_o SHALL be 0 while flush_i is 1.
- REQ-027: pxl_i SHALL be ignored when pxl_vld_i is 0, and the counter SHALL not advance.

Reset
- REQ-028: While rst_i is 1, counter, assembly register, cell_o, and cell_vld_o SHALL be 0, giving pxl_rdy_o = 1 and beat_idx_o = 0.
- REQ-029: Reset asserted mid-cell SHALL discard the partial cell and any pending output cell; after release, assembly restarts at beat 0.

Verification
- REQ-030: Twelve beats with pxl_i = 64'h0101..01 times k (k = 0..11), cell_rdy_i = 1 -> one cycle after beat 11, cell_vld_o = 1 and cell_o[767:704] = 0, cell_o[63:0] = 11 times 64'h0101..01.
- REQ-031: Back-to-back cells with cell_rdy_i held 0 -> beats 0..10 of the second cell are accepted, and pxl_rdy_o = 0 at beat_idx_o = 11 until cell_rdy_i = 1. Releasing cell_rdy_i completes the first transfer and the second load in the same cycle, and cell_vld_o stays 1.
- REQ-032: flush_i = 1 together with valid beat 5 -> next cycle beat_idx_o = 0, the beat is dropped, and a pending cell_o is unchanged.
- REQ-033: rst_i pulse asynchronous to clk_i at beat 7 with a cell pending -> cell_vld_o = 0 immediately, beat_idx_o = 0, and the next 12 beats form a correct cell.
- REQ-034: Random pxl_vld_i and cell_rdy_i gaps over 100 cells -> the scoreboard matches every cell bit-exactly, with no loss or duplication.
- REQ-035: Continuous valid and ready -> cell_vld_o pulses every 12 cycles and pxl_rdy_o is never 0.
